alu_exec_unit: RTL and testbench

Parametrised, handshaked execution unit for the RV32I datapath: decodes `ALUOp`/`Funct` into a 4-bit operation and executes it on `WIDTH`-bit operands. Extends the previous ALU control with the full RV32I integer operation set, I-type decode, an illegal-encoding flag and a registered valid/ready result. Shifts are iterative (multi-cycle) by default. Sits between the register-read stage and writeback.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_decode.sv | 52 +++++
 rtl/alu_exec_unit.sv | 147 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, ALUOp constants and FSM state type shared by
// the execution unit and the decoder (also used by the hazard unit).
// Optional feature macro: ALU_FAST_SHIFT_EN (single-cycle barrel shifter).
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} alu_state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} alu_state_t;
`endif

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational {ALUOp, Funct} -> {Operation, illegal}.
// Undefined encodings decode to ADD with illegal raised.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [3:0] Funct,
  output logic [3:0] Operation,
  output logic       illegal
);

  // Map the ALUOp class and {funct7[5], funct3} onto an operation code
  always_comb begin
    Operation = OP_ADD;
    illegal   = 1'b0;
    case (ALUOp)
      ALUOP_ADD: Operation = OP_ADD;
      ALUOP_SUB: Operation = OP_SUB;
      ALUOP_RTYPE: begin
        case (Funct)
          4'b0000: Operation = OP_ADD;
          4'b1000: Operation = OP_SUB;
          4'b0111: Operation = OP_AND;
          4'b0110: Operation = OP_OR;
          4'b0100: Operation = OP_XOR;
          4'b0001: Operation = OP_SLL;
          4'b0101: Operation = OP_SRL;
          4'b1101: Operation = OP_SRA;
          4'b0010: Operation = OP_SLT;
          4'b0011: Operation = OP_SLTU;
          default: illegal   = 1'b1;
        endcase
      end
      default: begin
        case (Funct[2:0])
          3'b000: Operation = OP_ADD;
          3'b001: begin
            if (Funct[3]) illegal = 1'b1;
            else          Operation = OP_SLL;
          end
          3'b010: Operation = OP_SLT;
          3'b011: Operation = OP_SLTU;
          3'b100: Operation = OP_XOR;
          3'b101: Operation = Funct[3] ? OP_SRA : OP_SRL;
          3'b110: Operation = OP_OR;
          default: Operation = OP_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked RV32I execution unit with registered result.
// Shifts run one bit per cycle unless ALU_FAST_SHIFT_EN is defined, in which
// case a barrel shifter gives every operation single-cycle latency.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       ALUOp,
  input  logic [3:0]       Funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [3:0]       Operation,
  output logic             out_valid,
  input  logic             out_ready
);

  alu_state_t       state, state_n;
  logic [3:0]       dec_op, op_q, op_d;
  logic             dec_ill, ill_q, ill_d;
  logic [WIDTH-1:0] alu_res, res_q, res_d;
  logic [SHW-1:0]   shamt;
`ifndef ALU_FAST_SHIFT_EN
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_step;
`endif

  alu_decode u_decode (
    .ALUOp     (ALUOp),
    .Funct     (Funct),
    .Operation (dec_op),
    .illegal   (dec_ill)
  );

  assign shamt     = b[SHW-1:0];
  assign result    = res_q;
  assign zero      = (res_q == '0);
  assign Operation = op_q;
  assign illegal   = ill_q;

  // Single-cycle result of the freshly decoded request
  always_comb begin
    alu_res = a + b;
    case (dec_op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
`else
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;
`endif
      default: alu_res = a + b;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  // One-bit step of the iterative shifter, direction taken from the held op
  always_comb begin
    case (op_q)
      OP_SLL:  shift_step = res_q << 1;
      OP_SRL:  shift_step = res_q >> 1;
      default: shift_step = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
    endcase
  end
`endif

  // Next state, handshake outputs and next datapath values
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    res_d     = res_q;
    op_d      = op_q;
    ill_d     = ill_q;
`ifndef ALU_FAST_SHIFT_EN
    cnt_d     = cnt_q;
`endif
    case (state)
      IDLE: in_ready = 1'b1;
`ifndef ALU_FAST_SHIFT_EN
      SHIFT: begin
        res_d = shift_step;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_n = HOLD;
      end
`endif
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (in_valid && in_ready) begin
      op_d    = dec_op;
      ill_d   = dec_ill;
      res_d   = alu_res;
      state_n = HOLD;
`ifndef ALU_FAST_SHIFT_EN
      if (is_shift(dec_op) && (shamt != '0)) begin
        cnt_d   = shamt;
        state_n = SHIFT;
      end
`endif
    end
  end

  // State register; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Result, operation, illegal flag and shift counter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_q <= '0;
      op_q  <= OP_ADD;
      ill_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q <= '0;
`endif
    end else begin
      res_q <= res_d;
      op_q  <= op_d;
      ill_q <= ill_d;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with literal expectations plus a
// queue-based reference model checked every cycle.
// Honours ALU_FAST_SHIFT_EN for expected shift latency.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  ALUOp;
  logic [3:0]  Funct;
  logic [31:0] a, b;
  logic        in_valid, in_ready;
  logic [31:0] result;
  logic        zero, illegal;
  logic [3:0]  Operation;
  logic        out_valid, out_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  op;
    logic        ill;
    int          due;
  } exp_t;

  exp_t q[$];

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ALUOp     (ALUOp),
    .Funct     (Funct),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .Operation (Operation),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: normalise every encoding onto the R-type funct table
  function automatic exp_t model(input logic [1:0] aop, input logic [3:0] f,
                                 input logic [31:0] x, input logic [31:0] y, input int now);
    exp_t e;
    logic [3:0] key;
    int sh;
    int lat;
    sh = int'(y[4:0]);
    lat = 0;
    case (aop)
      2'b00:   key = 4'b0000;
      2'b01:   key = 4'b1000;
      2'b10:   key = f;
      default: key = (f == 4'b1001) ? 4'b1111 : ((f[2:0] == 3'b101) ? f : {1'b0, f[2:0]});
    endcase
    e.ill = 1'b0;
    case (key)
      4'b0000: begin e.res = x + y; e.op = 4'b0010; end
      4'b1000: begin e.res = x - y; e.op = 4'b0110; end
      4'b0111: begin e.res = x & y; e.op = 4'b0000; end
      4'b0110: begin e.res = x | y; e.op = 4'b0001; end
      4'b0100: begin e.res = x ^ y; e.op = 4'b0011; end
      4'b0001: begin e.res = x << sh; e.op = 4'b0100; lat = sh; end
      4'b0101: begin e.res = x >> sh; e.op = 4'b0101; lat = sh; end
      4'b1101: begin
        e.res = (x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
        e.op  = 4'b1000;
        lat   = sh;
      end
      4'b0010: begin e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; e.op = 4'b0111; end
      4'b0011: begin e.res = (x < y) ? 32'd1 : 32'd0; e.op = 4'b1001; end
      default: begin e.res = x + y; e.op = 4'b0010; e.ill = 1'b1; end
    endcase
`ifdef ALU_FAST_SHIFT_EN
    lat = 0;
`endif
    e.due = now + 1 + lat;
    return e;
  endfunction

  // Per-cycle comparison of handshake and result against the model queue
  always @(negedge clk) begin : compare
    logic ev, er;
    if (!reset_n) begin
      q.delete();
    end else begin
      ev = (q.size() > 0) && (cyc >= q[0].due);
      er = (q.size() == 0) || (ev && out_ready);
      checkOutput("model out_valid", {31'b0, out_valid}, {31'b0, ev});
      checkOutput("model in_ready", {31'b0, in_ready}, {31'b0, er});
      if (ev) begin
        checkOutput("model result", result, q[0].res);
        checkOutput("model zero", {31'b0, zero}, {31'b0, (q[0].res == 32'h0)});
        checkOutput("model Operation", {28'b0, Operation}, {28'b0, q[0].op});
        checkOutput("model illegal", {31'b0, illegal}, {31'b0, q[0].ill});
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && er) q.push_back(model(ALUOp, Funct, a, b, cyc));
    end
  end

  // Drive one request and hold it until the unit accepts it
  task automatic applyStimulus(input logic [1:0] aop, input logic [3:0] f,
                               input logic [31:0] x, input logic [31:0] y, output int waited);
    bit ok;
    ALUOp = aop; Funct = f; a = x; b = y; in_valid = 1'b1;
    waited = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      waited++;
    end
    if (!ok) checkOutput("accept timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'hFFFF_FFFF; Funct = 4'b1111;
  endtask

  // Wait for a result and compare it with hand-computed literals
  task automatic waitResult(input string name, input logic [31:0] er,
                            input logic [3:0] eo, input logic ei);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) checkOutput({name, " out_valid timeout"}, 32'd0, 32'd1);
    checkOutput({name, " result"}, result, er);
    checkOutput({name, " zero"}, {31'b0, zero}, {31'b0, (er == 32'h0)});
    checkOutput({name, " Operation"}, {28'b0, Operation}, {28'b0, eo});
    checkOutput({name, " illegal"}, {31'b0, illegal}, {31'b0, ei});
    @(posedge clk); #1;
  endtask

  // Directed scenario sequence
  initial begin : main
    int w;
    int lowc;
    reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    ALUOp = 2'b10; Funct = 4'b0000; a = 32'd1; b = 32'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset zero", {31'b0, zero}, 32'd1);
    checkOutput("reset Operation", {28'b0, Operation}, 32'd2);
    checkOutput("reset illegal", {31'b0, illegal}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;

    applyStimulus(2'b10, 4'b1000, 32'd5, 32'd5, w);
    waitResult("sub 5-5", 32'h0, 4'b0110, 1'b0);
    applyStimulus(2'b10, 4'b1000, 32'd0, 32'd1, w);
    waitResult("sub 0-1", 32'hFFFF_FFFF, 4'b0110, 1'b0);
    applyStimulus(2'b10, 4'b0010, 32'hFFFF_FFFF, 32'd1, w);
    waitResult("slt", 32'd1, 4'b0111, 1'b0);
    applyStimulus(2'b10, 4'b0011, 32'hFFFF_FFFF, 32'd1, w);
    waitResult("sltu", 32'd0, 4'b1001, 1'b0);
    applyStimulus(2'b11, 4'b1001, 32'd7, 32'd5, w);
    waitResult("itype illegal", 32'd12, 4'b0010, 1'b1);
    applyStimulus(2'b10, 4'b1111, 32'd2, 32'd3, w);
    waitResult("rtype illegal", 32'd5, 4'b0010, 1'b1);
    applyStimulus(2'b10, 4'b0111, 32'hF0F0_1234, 32'h0FF0_FF00, w);
    waitResult("and", 32'h00F0_1200, 4'b0000, 1'b0);
    applyStimulus(2'b10, 4'b0110, 32'hF0F0_1234, 32'h0FF0_FF00, w);
    waitResult("or", 32'hFFF0_FF34, 4'b0001, 1'b0);
    applyStimulus(2'b10, 4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00, w);
    waitResult("xor", 32'hFF00_ED34, 4'b0011, 1'b0);
    applyStimulus(2'b00, 4'b1111, 32'hFFFF_FFFF, 32'd2, w);
    waitResult("aluop add wrap", 32'd1, 4'b0010, 1'b0);
    applyStimulus(2'b01, 4'b0000, 32'd3, 32'd5, w);
    waitResult("aluop sub", 32'hFFFF_FFFE, 4'b0110, 1'b0);
    applyStimulus(2'b11, 4'b1000, 32'd9, 32'd4, w);
    waitResult("itype add f7", 32'd13, 4'b0010, 1'b0);
    applyStimulus(2'b10, 4'b0000, 32'h7FFF_FFFF, 32'd1, w);
    waitResult("add overflow", 32'h8000_0000, 4'b0010, 1'b0);

    applyStimulus(2'b10, 4'b1101, 32'h8000_0000, 32'd31, w);
    lowc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (!in_ready) lowc++;
    end
`ifdef ALU_FAST_SHIFT_EN
    checkOutput("sra31 busy cycles", lowc, 32'd0);
`else
    checkOutput("sra31 busy cycles", lowc, 32'd31);
`endif
    waitResult("sra31", 32'hFFFF_FFFF, 4'b1000, 1'b0);
    applyStimulus(2'b10, 4'b1101, 32'h8000_0000, 32'd0, w);
    waitResult("sra0", 32'h8000_0000, 4'b1000, 1'b0);
    applyStimulus(2'b11, 4'b0001, 32'd1, 32'd31, w);
    waitResult("slli31", 32'h8000_0000, 4'b0100, 1'b0);
    applyStimulus(2'b11, 4'b0101, 32'h8000_0000, 32'd4, w);
    waitResult("srli4", 32'h0800_0000, 4'b0101, 1'b0);
    applyStimulus(2'b11, 4'b1101, 32'hF000_0000, 32'd4, w);
    waitResult("srai4", 32'hFF00_0000, 4'b1000, 1'b0);

    out_ready = 1'b0;
    applyStimulus(2'b10, 4'b0000, 32'd1, 32'd2, w);
    waitResult("bp first", 32'd3, 4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp hold out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp hold result", result, 32'd3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(2'b10, 4'b0100, 32'd6, 32'd3, w);
    checkOutput("b2b accept wait", w, 32'd0);
    waitResult("b2b xor", 32'd5, 4'b0011, 1'b0);

    applyStimulus(2'b10, 4'b1101, 32'h8000_0000, 32'd10, w);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("mid-reset no result", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      ALUOp = 2'b00; Funct = 4'b0000; a = 32'(i * 7); b = 32'd100; in_valid = 1'b1;
      @(negedge clk);
      checkOutput("stream in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("model queue drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
